// File: rtl/if_trace_pkg.sv
// Shared types for the instruction-fetch tracker: instruction kinds, RV32 major opcodes,
// the default-width trace record layout and the opcode classifier.
package if_trace_pkg;

  typedef enum logic [1:0] {
    KIND_LOAD  = 2'd0,
    KIND_STORE = 2'd1,
    KIND_CTRL  = 2'd2,
    KIND_OTHER = 2'd3
  } instr_kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int REC_ADDR_W = 16;
  localparam int REC_DATA_W = 32;
  localparam int REC_TS_W   = 32;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] instr;
    logic [REC_TS_W-1:0]   ts;
    instr_kind_e           kind;
  } trace_rec_t;

  // Compressed encodings (low bits != 2'b11) never match a 32-bit major opcode.
  function automatic instr_kind_e classify(input logic [6:0] opcode);
    instr_kind_e kind;
    if (opcode[1:0] != 2'b11) begin
      kind = KIND_OTHER;
    end else begin
      case (opcode)
        OPC_LOAD:                     kind = KIND_LOAD;
        OPC_STORE:                    kind = KIND_STORE;
        OPC_BRANCH, OPC_JAL, OPC_JALR: kind = KIND_CTRL;
        default:                      kind = KIND_OTHER;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/if_trace_fifo.sv
// Synchronous first-word-fall-through FIFO. Read data is forced to zero while empty so the
// storage array itself never needs a reset.
module if_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/if_trace_tracker.sv
// Instruction-fetch tracker: pairs req/gnt fetch addresses with rvalid responses, classifies
// each instruction and queues filtered {addr, instr, ts, kind} records for the trace merge stage.
module if_trace_tracker
  import if_trace_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 16,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int OUT_FIFO_DEPTH   = 4,
  parameter int TS_WIDTH         = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [TS_WIDTH-1:0]                      counter,
  input  logic                                     flush,
  input  logic [3:0]                               filter_mask,
  input  logic                                     instr_req,
  input  logic                                     instr_gnt,
  input  logic [INSTR_ADDR_WIDTH-1:0]              instr_addr,
  input  logic                                     instr_rvalid,
  input  logic [INSTR_DATA_WIDTH-1:0]              instr_rdata,
  output logic                                     trace_valid,
  input  logic                                     trace_ready,
  output logic [INSTR_ADDR_WIDTH-1:0]              trace_addr,
  output logic [INSTR_DATA_WIDTH-1:0]              trace_instr,
  output logic [TS_WIDTH-1:0]                      trace_ts,
  output logic [1:0]                               trace_kind,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic [15:0]                              drop_count,
  output logic                                     proto_err
);

  localparam int OCC_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int AQ_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCNT_W   = $clog2(OUT_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [INSTR_DATA_WIDTH-1:0] instr;
    logic [TS_WIDTH-1:0]         ts;
    instr_kind_e                 kind;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic logic [AQ_PTR_W-1:0] aq_ptr_inc(input logic [AQ_PTR_W-1:0] p);
    return (p == AQ_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + AQ_PTR_W'(1);
  endfunction

  function automatic logic [OCC_W-1:0] live_count(input logic [MAX_OUTSTANDING-1:0] live);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (live[i]) n = n + OCC_W'(1);
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address queue: circular buffer with per-slot valid and kill bits.
  logic [INSTR_ADDR_WIDTH-1:0] aq_addr_q [MAX_OUTSTANDING];
  logic [INSTR_ADDR_WIDTH-1:0] aq_addr_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0]  aq_vld_q, aq_vld_d;
  logic [MAX_OUTSTANDING-1:0]  aq_kill_q, aq_kill_d;
  logic [AQ_PTR_W-1:0]         aq_rd_q, aq_rd_d;
  logic [AQ_PTR_W-1:0]         aq_wr_q, aq_wr_d;
  logic [OCC_W-1:0]            outstanding_q, outstanding_d;
  logic [15:0]                 drop_count_q, drop_count_d;
  logic                        proto_err_q, proto_err_d;

  logic        grant, aq_full, aq_empty, aq_pop, aq_push;
  logic        head_kill, drop;
  instr_kind_e rsp_kind;
  rec_t        rec_in, rec_out;
  logic [REC_W-1:0] rec_out_bits;
  logic        rec_push, rec_accept, rec_pop;
  logic        fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  assign grant    = instr_req && instr_gnt;
  assign aq_full  = &aq_vld_q;
  assign aq_empty = ~|aq_vld_q;
  assign aq_pop   = instr_rvalid && !aq_empty;
  assign aq_push  = grant && (!aq_full || aq_pop);

  // A flush in the response cycle kills the head that is popping right now.
  assign head_kill = aq_kill_q[aq_rd_q] || flush;
  assign rsp_kind  = classify(instr_rdata[6:0]);
  assign rec_push  = aq_pop && !head_kill && filter_mask[rsp_kind];
  assign rec_in    = {aq_addr_q[aq_rd_q], instr_rdata, counter, rsp_kind};

  assign rec_pop    = trace_valid && trace_ready;
  assign rec_accept = rec_push && ((fifo_count != FCNT_W'(OUT_FIFO_DEPTH)) || rec_pop);
  assign drop       = rec_push && fifo_full && !rec_pop;

  always_comb begin
    aq_addr_d = aq_addr_q;
    aq_vld_d  = aq_vld_q;
    aq_rd_d   = aq_rd_q;
    aq_wr_d   = aq_wr_q;
    aq_kill_d = flush ? (aq_kill_q | aq_vld_q) : aq_kill_q;
    // Pop before push so a full queue can retire the head and accept a grant in one cycle.
    if (aq_pop) begin
      aq_vld_d[aq_rd_q] = 1'b0;
      aq_rd_d           = aq_ptr_inc(aq_rd_q);
    end
    if (aq_push) begin
      aq_addr_d[aq_wr_q] = instr_addr;
      aq_vld_d[aq_wr_q]  = 1'b1;
      aq_kill_d[aq_wr_q] = 1'b0;
      aq_wr_d            = aq_ptr_inc(aq_wr_q);
    end
    outstanding_d = live_count(aq_vld_d & ~aq_kill_d);
    proto_err_d   = proto_err_q
                 || (instr_rvalid && aq_empty)
                 || (grant && aq_full && !aq_pop);
    drop_count_d  = drop ? sat_inc16(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aq_vld_q      <= '0;
      aq_kill_q     <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
      outstanding_q <= '0;
      drop_count_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      aq_vld_q      <= aq_vld_d;
      aq_kill_q     <= aq_kill_d;
      aq_rd_q       <= aq_rd_d;
      aq_wr_q       <= aq_wr_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    aq_addr_q <= aq_addr_d;
  end

  if_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rec_accept),
    .wr_data (rec_in),
    .rd_en   (rec_pop),
    .rd_data (rec_out_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rec_out     = rec_out_bits;
  assign trace_valid = !fifo_empty;
  assign trace_addr  = rec_out.addr;
  assign trace_instr = rec_out.instr;
  assign trace_ts    = rec_out.ts;
  assign trace_kind  = rec_out.kind;
  assign outstanding = outstanding_q;
  assign drop_count  = drop_count_q;
  assign proto_err   = proto_err_q;

endmodule
